// File: rtl/sqrt_iter.sv
// Multi-cycle integer square root: non-restoring digit recurrence, STEPS root bits per clock,
// with valid/ready handshakes on operand and result.
module sqrt_iter #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   num,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem,
    output logic               busy
);

    localparam int RW    = WIDTH / 2;
    localparam int ITERS = RW / STEPS;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

    state_e          state_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [RW-1:0]    q_q, q_d;
    logic [RW+1:0]    r_q, r_d;   // two's-complement partial remainder
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    root_q;
    logic [RW:0]      rem_q;
    logic [RW+1:0]    left_v, right_v, r_fixed;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_d     = a_q;
        q_d     = q_q;
        r_d     = r_q;
        left_v  = '0;
        right_v = '0;
        for (int s = 0; s < STEPS; s++) begin
            right_v = {q_d, r_d[RW+1], 1'b1};
            left_v  = {r_d[RW-1:0], a_d[WIDTH-1 -: 2]};
            a_d     = a_d << 2;
            r_d     = r_d[RW+1] ? left_v + right_v : left_v - right_v;
            q_d     = {q_d[RW-2:0], ~r_d[RW+1]};
        end
    end

    // A negative final remainder is corrected by adding back 2q+1.
    assign r_fixed = r_q + {1'b0, q_q, 1'b1};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= num;
                    q_q     <= '0;
                    r_q     <= '0;
                    cnt_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    root_q  <= q_q;
                    rem_q   <= r_q[RW+1] ? r_fixed[RW:0] : r_q[RW:0];
                    state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY) || (state_q == FIX);
    assign root      = root_q;
    assign rem       = rem_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: a 32-bit/1-step unit for corners, handshakes and reset,
// plus a 16-bit/4-step unit checked against a search-based floor root.
module tb_sqrt_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [31:0] a_num;
    logic [15:0] a_root;
    logic [16:0] a_rem;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [15:0] b_num;
    logic [7:0]  b_root;
    logic [8:0]  b_rem;

    int total = 0;
    int bad   = 0;

    sqrt_iter #(.WIDTH(32), .STEPS(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .num(a_num),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .root(a_root), .rem(a_rem), .busy(a_busy)
    );

    sqrt_iter #(.WIDTH(16), .STEPS(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .num(b_num),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .root(b_root), .rem(b_rem), .busy(b_busy)
    );

    // Accept one operand on dut_a, count edges until out_valid, capture, then hand it off.
    task automatic a_run(input logic [31:0] n, output logic [15:0] r, output logic [16:0] m, output int lat);
        a_num = n; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_num = ~n;
        lat = 0;
        while (!a_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        r = a_root; m = a_rem;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        total++; if (a_root !== 16'h0 || a_rem !== 17'h0) begin bad++; $display("FAIL reset_result: got root=%0h rem=%0h want 0/0", a_root, a_rem); end
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_corners();
        logic [15:0] r; logic [16:0] m; int lat;
        a_run(32'd0, r, m, lat);
        total++; if (r !== 16'h0 || m !== 17'h0) begin bad++; $display("FAIL zero: got root=%0h rem=%0h want 0/0", r, m); end
        total++; if (lat !== 17) begin bad++; $display("FAIL zero_latency: got %0d want 17", lat); end
        a_run(32'hFFFF_FFFF, r, m, lat);
        total++; if (r !== 16'hFFFF || m !== 17'h1FFFE) begin bad++; $display("FAIL all_ones: got root=%0h rem=%0h want ffff/1fffe", r, m); end
        total++; if (lat !== 17) begin bad++; $display("FAIL all_ones_latency: got %0d want 17", lat); end
    endtask

    task automatic test_values();
        logic [31:0] vn [3] = '{32'd1000000, 32'd99, 32'd2};
        logic [15:0] vr [3] = '{16'd1000, 16'd9, 16'd1};
        logic [16:0] vm [3] = '{17'd0, 17'd18, 17'd1};
        logic [15:0] r; logic [16:0] m; int lat;
        for (int i = 0; i < 3; i++) begin
            a_run(vn[i], r, m, lat);
            total++;
            if (r !== vr[i] || m !== vm[i] || lat !== 17) begin
                bad++;
                $display("FAIL value num=%0d: got root=%0d rem=%0d lat=%0d want %0d/%0d/17", vn[i], r, m, lat, vr[i], vm[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        a_num = 32'd50; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        total++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_busy: got busy=%b in_ready=%b want 1/0", a_busy, a_in_ready); end
        while (!a_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 17) begin bad++; $display("FAIL bp_latency: got %0d want 17", lat); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 6) begin a_in_valid = 1'b1; a_num = 32'd12345; end
            @(posedge clk); #1;
            a_in_valid = 1'b0;
            total++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_root !== 16'd7 || a_rem !== 17'd1) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b root=%0d rem=%0d want 1/0/7/1", i, a_out_valid, a_in_ready, a_root, a_rem);
            end
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got ir=%b ov=%b want 1/0", a_in_ready, a_out_valid); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ignored_input: got busy=%b ir=%b want 0/1", a_busy, a_in_ready); end
    endtask

    task automatic test_reset_mid_busy();
        logic [15:0] r; logic [16:0] m; int lat;
        bit seen = 1'b0;
        a_num = 32'd1000; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_root !== 16'h0 || a_rem !== 17'h0) begin
            bad++;
            $display("FAIL mid_reset_state: got ir=%b ov=%b busy=%b root=%0h rem=%0h want 1/0/0/0/0", a_in_ready, a_out_valid, a_busy, a_root, a_rem);
        end
        for (int i = 0; i < 25; i++) begin @(posedge clk); #1; if (a_out_valid) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_no_result: got out_valid seen=%b want 0", seen); end
        a_run(32'd144, r, m, lat);
        total++; if (r !== 16'd12 || m !== 17'd0 || lat !== 17) begin bad++; $display("FAIL after_reset_144: got root=%0d rem=%0d lat=%0d want 12/0/17", r, m, lat); end
    endtask

    task automatic test_back_to_back();
        int t = 0, first = -1, second = -1;
        bit ok = 1'b1;
        a_num = 32'd625; a_in_valid = 1'b1; a_out_ready = 1'b1;
        while (second < 0 && t < 200) begin
            @(posedge clk); #1; t++;
            if (a_out_valid) begin
                if (a_root !== 16'd25 || a_rem !== 17'd0) ok = 1'b0;
                if (first < 0) first = t; else second = t;
            end
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        total++; if (first !== 18) begin bad++; $display("FAIL b2b_first: got %0d want 18", first); end
        total++; if (second - first !== 19) begin bad++; $display("FAIL b2b_period: got %0d want 19", second - first); end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_result: got ok=%b want 1", ok); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle: got %b want 1", a_in_ready); end
    endtask

    function automatic logic [7:0] isqrt16(input logic [15:0] n);
        for (int r = 255; r >= 0; r--) if (r * r <= int'(n)) return 8'(r);
        return 8'd0;
    endfunction

    task automatic test_steps4();
        logic [15:0] ops [$];
        logic [7:0]  er;
        logic [8:0]  em;
        int lat;
        ops.push_back(16'h0000);
        ops.push_back(16'hFFFF);
        for (int k = 0; k < 8; k++) ops.push_back(16'(1 << (2 * k)));
        for (int k = 0; k < 12; k++) ops.push_back(16'($urandom));
        foreach (ops[i]) begin
            er = isqrt16(ops[i]);
            em = 9'(int'(ops[i]) - int'(er) * int'(er));
            b_num = ops[i]; b_in_valid = 1'b1;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            lat = 0;
            while (!b_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
            total++;
            if (b_root !== er || b_rem !== em || lat !== 3) begin
                bad++;
                $display("FAIL steps4 num=%0h: got root=%0h rem=%0h lat=%0d want %0h/%0h/3", ops[i], b_root, b_rem, lat, er, em);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_num = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_num = '0;
        test_reset();
        test_corners();
        test_values();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_steps4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
